renkon_ctrl_pool: RTL and testbench
===================================

Name: renkon_ctrl_pool

Overview:
- Sequencer for the renkon max-pooling datapath (feature line buffer plus max tree).
- Walks each channel's feature map in raster order and issues feature-memory read addresses.
- Drives buf_feat_en and out_en aligned to pixel arrival, and emits output-memory write addresses and strobes for every completed, non-overlapping pool window.
- Sits between the ninjin-side configuration registers and the pool datapath.

Parameters:
- LWIDTH, 10, width of size and count fields.
- AWIDTH, 12, feature/output memory address width.
- RD_LAT, 1, cycles from read address to pixel_in valid at datapath.
- POOL_LAT, 2, cycles from out_en to pool result valid at pixel_out.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begin job
- fea_size  in  LWIDTH  feature map side length F
- pool_size  in  LWIDTH  window side and stride P
- n_chan  in  LWIDTH  number of channels C
- read_base  in  AWIDTH  first feature address
- write_base  in  AWIDTH  first output address
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  invalid configuration latched
- mem_feat_addr  out  AWIDTH  feature memory read address
- buf_feat_en  out  1  line-buffer shift enable, aligned to pixel_in
- w_fea_size  out  LWIDTH  latched F to linebuf
- w_pool_size  out  LWIDTH  latched P to linebuf
- out_en  out  1  pool tree capture strobe
- mem_out_addr  out  AWIDTH  output memory write address
- mem_out_we  out  1  output memory write strobe, aligned to pixel_out valid

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-job aborts immediately. No done pulse; pipelines cleared.
- Configuration latch: on start in IDLE, latch all config inputs. w_fea_size and w_pool_size hold their values until the next accepted start.
- start is ignored while busy.
- States:
  - IDLE: on start, go to CHECK.
  - CHECK (1 cycle): valid when 2<=P<=5, P<=F and C>=1. Valid goes to FEED. Invalid sets err, goes to DONE, and produces no reads or writes. err clears on the next accepted start.
  - FEED: one read per cycle. mem_feat_addr = read_base + ch*F*F + r*F + c, computed incrementally with no multiplier in the loop. Column counter c wraps at F-1 and increments r; r wraps at F-1 and increments ch. After the last pixel (ch=C-1, r=c=F-1) go to DRAIN.
  - DRAIN: wait until the read, out_en and write pipelines are empty, then go to DONE.
  - DONE (1 cycle): done=1, then IDLE.
- busy: 1 in every state except IDLE.
- Alignment: buf_feat_en asserts exactly RD_LAT cycles after each read issue; implement with a shift register carrying valid, r-phase and c-phase.
- Window completion: out_en=1 in the same cycle as buf_feat_en for pixel (r,c) when r mod P = P-1 and c mod P = P-1, and r, c lie inside a full window.
  - Trailing rows/columns when F is not a multiple of P produce no out_en.
  - Phase counters reset per channel; no window spans channels or rows.
- Writes: mem_out_we asserts POOL_LAT cycles after each out_en.
  - mem_out_addr starts at write_base and increments by 1 after each write, continuing across channels.
  - Total writes = C*floor(F/P)^2.
- Address overflow wraps modulo 2^AWIDTH and is not flagged.
- When done, mem_out_we and buf_feat_en have both been 0 for at least 1 cycle.

Test Plan:
- F=4, P=2, C=1, read_base=0, write_base=100, start at cycle 0.
  - Reads addr 0..15 at cycles 2..17.
  - buf_feat_en at cycles 3..18.
  - out_en at cycles 8,10,16,18.
  - mem_out_we at 10,12,18,20 with addr 100..103.
  - done at cycle 21.
- F=5, P=2, C=2, read_base=50: reads 50..99; 8 writes total; no out_en for row 4 or column 4 pixels.
- F=6, P=3, C=1: out_en only at pixel indices 14,17,32,35; 4 writes.
- Invalid configs, each tested separately (P=1; P=7 with F=6; C=0): err=1, done pulses 2 cycles after start, zero reads and zero writes.
- start pulsed again mid-FEED: ignored; address sequence and write count unchanged.
- rst asserted at cycle 9 of the first scenario: next cycle all outputs 0 and busy=0. A new start then runs the first scenario cleanly with done after 21 cycles.

Source files
------------

// File: rtl/renkon_ctrl_pool.sv
`default_nettype none
// ============================================================================
// renkon_ctrl_pool : raster sequencer and write scheduler for the max-pool path
// Revision: 1.0
// ============================================================================
module renkon_ctrl_pool #(
  parameter int LWIDTH   = 10,
  parameter int AWIDTH   = 12,
  parameter int RD_LAT   = 1,
  parameter int POOL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LWIDTH-1:0] fea_size,
  input  logic [LWIDTH-1:0] pool_size,
  input  logic [LWIDTH-1:0] n_chan,
  input  logic [AWIDTH-1:0] read_base,
  input  logic [AWIDTH-1:0] write_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] mem_feat_addr,
  output logic              buf_feat_en,
  output logic [LWIDTH-1:0] w_fea_size,
  output logic [LWIDTH-1:0] w_pool_size,
  output logic              out_en,
  output logic [AWIDTH-1:0] mem_out_addr,
  output logic              mem_out_we
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [LWIDTH-1:0] fea_q, pool_q, chan_q;
  logic [AWIDTH-1:0] rbase_q, addr_q, out_addr_q;
  logic [LWIDTH-1:0] c_q, r_q, ch_q, pc_q, pr_q;
  logic              err_q;
  logic [RD_LAT-1:0]   rd_vld_q, rd_rph_q, rd_cph_q;
  logic [POOL_LAT-1:0] we_q;

  logic w_start_ok, w_cfg_ok, w_issue;
  logic w_c_last, w_r_last, w_ch_last, w_last;
  logic w_pc_end, w_pr_end, w_drain_busy;
  logic [POOL_LAT-1:0] w_we_early;

  assign w_start_ok = start && (state_q == S_IDLE);
  assign w_cfg_ok   = (pool_q >= LWIDTH'(2)) && (pool_q <= LWIDTH'(5)) &&
                      (pool_q <= fea_q) && (chan_q != '0);
  assign w_issue    = (state_q == S_FEED);

  assign w_c_last  = (c_q == fea_q - LWIDTH'(1));
  assign w_r_last  = (r_q == fea_q - LWIDTH'(1));
  assign w_ch_last = (ch_q == chan_q - LWIDTH'(1));
  assign w_last    = w_c_last && w_r_last && w_ch_last;
  // Phase reaching P-1 implies a complete window; trailing partial windows never get there.
  assign w_pc_end  = (pc_q == pool_q - LWIDTH'(1));
  assign w_pr_end  = (pr_q == pool_q - LWIDTH'(1));

  // The last write stage may still be active on the cycle DONE is entered.
  assign w_we_early   = we_q << 1;
  assign w_drain_busy = (|rd_vld_q) || (|w_we_early);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = w_cfg_ok ? S_FEED : S_DONE;
      S_FEED:  if (w_last) state_d = S_DRAIN;
      S_DRAIN: if (!w_drain_busy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fea_q      <= '0;
      pool_q     <= '0;
      chan_q     <= '0;
      rbase_q    <= '0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
    end else if (w_start_ok) begin
      fea_q      <= fea_size;
      pool_q     <= pool_size;
      chan_q     <= n_chan;
      rbase_q    <= read_base;
      out_addr_q <= write_base;
      err_q      <= 1'b0;
    end else begin
      if (state_q == S_CHECK && !w_cfg_ok) err_q <= 1'b1;
      if (mem_out_we) out_addr_q <= out_addr_q + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      c_q    <= '0;
      r_q    <= '0;
      ch_q   <= '0;
      pc_q   <= '0;
      pr_q   <= '0;
    end else if (state_q == S_CHECK) begin
      addr_q <= rbase_q;
      c_q    <= '0;
      r_q    <= '0;
      ch_q   <= '0;
      pc_q   <= '0;
      pr_q   <= '0;
    end else if (state_q == S_FEED) begin
      // Raster order across channels is contiguous, so the address just counts.
      if (!w_last) addr_q <= addr_q + AWIDTH'(1);
      if (w_c_last) begin
        c_q  <= '0;
        pc_q <= '0;
        if (w_r_last) begin
          r_q  <= '0;
          pr_q <= '0;
          ch_q <= ch_q + LWIDTH'(1);
        end else begin
          r_q  <= r_q + LWIDTH'(1);
          pr_q <= w_pr_end ? '0 : pr_q + LWIDTH'(1);
        end
      end else begin
        c_q  <= c_q + LWIDTH'(1);
        pc_q <= w_pc_end ? '0 : pc_q + LWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= '0;
      rd_rph_q <= '0;
      rd_cph_q <= '0;
      we_q     <= '0;
    end else begin
      rd_vld_q[0] <= w_issue;
      rd_rph_q[0] <= w_issue && w_pr_end;
      rd_cph_q[0] <= w_issue && w_pc_end;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_rph_q[i] <= rd_rph_q[i-1];
        rd_cph_q[i] <= rd_cph_q[i-1];
      end
      we_q[0] <= out_en;
      for (int i = 1; i < POOL_LAT; i++) we_q[i] <= we_q[i-1];
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign mem_feat_addr = addr_q;
  assign buf_feat_en   = rd_vld_q[RD_LAT-1];
  assign out_en        = rd_vld_q[RD_LAT-1] && rd_rph_q[RD_LAT-1] && rd_cph_q[RD_LAT-1];
  assign mem_out_we    = we_q[POOL_LAT-1];
  assign mem_out_addr  = out_addr_q;
  assign w_fea_size    = fea_q;
  assign w_pool_size   = pool_q;

endmodule
`default_nettype wire

// File: tb/tb_renkon_ctrl_pool.sv
`default_nettype none
// ============================================================================
// tb_renkon_ctrl_pool : directed checks of sequencing, alignment and writes
// Revision: 1.0
// ============================================================================
module tb_renkon_ctrl_pool;
  localparam int LW = 10;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] fea_size = '0, pool_size = '0, n_chan = '0;
  logic [AW-1:0] read_base = '0, write_base = '0;
  logic          busy, done, err, buf_feat_en, out_en, mem_out_we;
  logic [AW-1:0] mem_feat_addr, mem_out_addr;
  logic [LW-1:0] w_fea_size, w_pool_size;

  always #5 clk = ~clk;

  renkon_ctrl_pool #(.LWIDTH(LW), .AWIDTH(AW), .RD_LAT(1), .POOL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fea_size(fea_size), .pool_size(pool_size), .n_chan(n_chan),
    .read_base(read_base), .write_base(write_base),
    .busy(busy), .done(done), .err(err),
    .mem_feat_addr(mem_feat_addr), .buf_feat_en(buf_feat_en),
    .w_fea_size(w_fea_size), .w_pool_size(w_pool_size),
    .out_en(out_en), .mem_out_addr(mem_out_addr), .mem_out_we(mem_out_we)
  );

  int cyc = 0;
  int t0 = 0;
  int done_cyc = -1;
  int be_cyc[$], oe_cyc[$], we_cyc[$], rd_addr[$], we_addr[$];
  logic [AW-1:0] prev_addr = '0;
  int n_pass = 0, n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // With RD_LAT=1 the address of a read is the one shown the cycle before buf_feat_en.
  always @(negedge clk) begin
    if (buf_feat_en) begin
      be_cyc.push_back(cyc - t0);
      rd_addr.push_back(int'(prev_addr));
    end
    if (out_en) oe_cyc.push_back(cyc - t0);
    if (mem_out_we) begin
      we_cyc.push_back(cyc - t0);
      we_addr.push_back(int'(mem_out_addr));
    end
    if (done && done_cyc < 0) done_cyc = cyc - t0;
    prev_addr = mem_feat_addr;
  end

  function automatic logic [63:0] outs();
    return 64'({busy, done, err, buf_feat_en, out_en, mem_out_we,
                mem_feat_addr, mem_out_addr, w_fea_size, w_pool_size});
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic launch(input int f, input int p, input int c, input int rb, input int wb);
    @(posedge clk); #1;
    fea_size   = LW'(f);
    pool_size  = LW'(p);
    n_chan     = LW'(c);
    read_base  = AW'(rb);
    write_base = AW'(wb);
    be_cyc.delete(); oe_cyc.delete(); we_cyc.delete();
    rd_addr.delete(); we_addr.delete();
    done_cyc = -1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int restart_at);
    for (int k = 0; k < 400; k++) begin
      if (done_cyc >= 0) break;
      @(posedge clk); #1;
      start = ((cyc - t0) == restart_at);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic seq_q(input int base, input int n, output int q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back((base + i) % 4096);
  endtask

  task automatic check_s1(input string pfx);
    int e[$];
    seq_q(0, 16, e);
    check_q({pfx, "_rd_addr"}, rd_addr, e);
    check({pfx, "_first_buf_en"}, (be_cyc.size() > 0) ? be_cyc[0] : -1, 3);
    check({pfx, "_last_buf_en"}, (be_cyc.size() > 0) ? be_cyc[be_cyc.size()-1] : -1, 18);
    e = '{8, 10, 16, 18};
    check_q({pfx, "_out_en_cyc"}, oe_cyc, e);
    e = '{10, 12, 18, 20};
    check_q({pfx, "_we_cyc"}, we_cyc, e);
    seq_q(100, 4, e);
    check_q({pfx, "_we_addr"}, we_addr, e);
    check({pfx, "_done_cyc"}, done_cyc, 21);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_w_fea_size"}, w_fea_size, 4);
    check({pfx, "_w_pool_size"}, w_pool_size, 2);
    check({pfx, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int e[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", outs(), 0);

    // F=4 P=2 C=1
    launch(4, 2, 1, 0, 100);
    check("s1_busy_check", busy, 1);
    wait_done(-1);
    check_s1("s1");

    // F=5 P=2 C=2: trailing row/column produce no window
    launch(5, 2, 2, 50, 7);
    wait_done(-1);
    seq_q(50, 50, e);
    check_q("s2_rd_addr", rd_addr, e);
    e = '{9, 11, 19, 21, 34, 36, 44, 46};
    check_q("s2_out_en_cyc", oe_cyc, e);
    e = '{11, 13, 21, 23, 36, 38, 46, 48};
    check_q("s2_we_cyc", we_cyc, e);
    seq_q(7, 8, e);
    check_q("s2_we_addr", we_addr, e);
    check("s2_done_cyc", done_cyc, 54);

    // F=6 P=3 C=1 with both address spaces wrapping
    launch(6, 3, 1, 4090, 4094);
    wait_done(-1);
    seq_q(4090, 36, e);
    check_q("s3_rd_addr", rd_addr, e);
    e = '{17, 20, 35, 38};
    check_q("s3_out_en_cyc", oe_cyc, e);
    e = '{4094, 4095, 0, 1};
    check_q("s3_we_addr", we_addr, e);
    check("s3_done_cyc", done_cyc, 41);

    // Invalid configurations
    launch(4, 1, 1, 0, 0);
    wait_done(-1);
    check("inv_p1_err", err, 1);
    check("inv_p1_done_cyc", done_cyc, 2);
    check("inv_p1_reads", be_cyc.size(), 0);
    check("inv_p1_writes", we_cyc.size(), 0);

    launch(6, 7, 1, 0, 0);
    wait_done(-1);
    check("inv_p7_err", err, 1);
    check("inv_p7_done_cyc", done_cyc, 2);
    check("inv_p7_reads", be_cyc.size(), 0);
    check("inv_p7_writes", we_cyc.size(), 0);

    launch(4, 2, 0, 0, 0);
    wait_done(-1);
    check("inv_c0_err", err, 1);
    check("inv_c0_done_cyc", done_cyc, 2);
    check("inv_c0_reads", be_cyc.size(), 0);
    check("inv_c0_writes", we_cyc.size(), 0);

    // start pulsed again mid-FEED is ignored
    launch(4, 2, 1, 0, 100);
    wait_done(6);
    check_s1("restart");

    // Reset mid-job aborts without a done pulse
    launch(4, 2, 1, 0, 100);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outs", outs(), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cyc, -1);
    check("abort_busy", busy, 0);
    launch(4, 2, 1, 0, 100);
    wait_done(-1);
    check_s1("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
